// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared request/ready memory port, steers datapath muxes and counts retirements.
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [2:0]  imm_sel,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        halt,
    output logic        err,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OPIMM  = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    state_t      r_state;
    logic [6:0]  r_opc;
    logic [2:0]  r_imm_sel;
    logic        r_halt;
    logic        r_err;
    logic [31:0] r_instret;

    logic [6:0]  w_opc;
    logic [2:0]  w_imm_dec;
    logic        w_legal;
    logic        w_alu_a;
    logic        w_alu_b;
    logic        w_retire;

    assign w_opc = instr[6:0];

    always_comb begin
        w_imm_dec = 3'd0;
        w_legal   = 1'b1;
        case (w_opc)
            OP_LUI, OP_AUIPC: w_imm_dec = 3'd3;
            OP_JAL:           w_imm_dec = 3'd4;
            OP_BRANCH:        w_imm_dec = 3'd2;
            OP_STORE:         w_imm_dec = 3'd1;
            OP_JALR, OP_LOAD, OP_OPIMM, OP_OP, OP_SYSTEM: w_imm_dec = 3'd0;
            default:          w_legal = 1'b0;
        endcase
    end

    // ALU operand selects depend only on the latched opcode and hold from EXEC to WB.
    assign w_alu_a = (r_opc == OP_AUIPC);
    assign w_alu_b = (r_opc == OP_AUIPC) || (r_opc == OP_OPIMM) ||
                     (r_opc == OP_LOAD)  || (r_opc == OP_STORE);

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        w_retire  = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                // Reset aborts the fetch before the IR can be loaded.
                ir_we   = mem_ready & ~rst;
            end
            S_EXEC: begin
                alu_src_a = w_alu_a;
                alu_src_b = w_alu_b;
                case (r_opc)
                    OP_BRANCH: begin
                        pc_we    = 1'b1;
                        pc_src   = {1'b0, br_taken};
                        w_retire = 1'b1;
                    end
                    OP_JAL, OP_JALR: begin
                        rf_we    = 1'b1;
                        wb_sel   = 2'd2;
                        pc_we    = 1'b1;
                        pc_src   = (r_opc == OP_JAL) ? 2'd1 : 2'd2;
                        w_retire = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                addr_sel  = 1'b1;
                mem_we    = (r_opc == OP_STORE);
                alu_src_a = w_alu_a;
                alu_src_b = w_alu_b;
                if (mem_ready && r_opc == OP_STORE) begin
                    pc_we    = 1'b1;
                    w_retire = 1'b1;
                end
            end
            S_WB: begin
                alu_src_a = w_alu_a;
                alu_src_b = w_alu_b;
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                w_retire  = 1'b1;
                if (r_opc == OP_LUI)       wb_sel = 2'd3;
                else if (r_opc == OP_LOAD) wb_sel = 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_opc     <= 7'd0;
            r_imm_sel <= 3'd0;
            r_halt    <= 1'b0;
            r_err     <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_opc     <= w_opc;
                    r_imm_sel <= w_imm_dec;
                    if (instr == 32'h0000_0073) begin
                        r_halt  <= 1'b1;
                        r_state <= S_HALT;
                    end else if (!w_legal || w_opc == OP_SYSTEM) begin
                        r_err   <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (r_opc)
                        OP_BRANCH, OP_JAL, OP_JALR: r_state <= S_FETCH;
                        OP_LOAD, OP_STORE:          r_state <= S_MEM;
                        default:                    r_state <= S_WB;
                    endcase
                end
                S_MEM: if (mem_ready) r_state <= (r_opc == OP_LOAD) ? S_WB : S_FETCH;
                S_WB:   r_state <= S_FETCH;
                default: r_state <= S_HALT;
            endcase
            if (w_retire) r_instret <= r_instret + 32'd1;
        end
    end

    assign imm_sel = (r_state == S_DECODE) ? w_imm_dec : r_imm_sel;
    assign halt    = r_halt;
    assign err     = r_err;
    assign instret = r_instret;

endmodule
